// File: rtl/biquad_coef_loader.sv
// Byte-stream coefficient loader feeding the biquad parameter port; frames are shadowed, then written on ready.
// Define BIQUAD_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module biquad_coef_loader #(
  parameter int         data_width  = 16,
  parameter logic [7:0] HEADER_BYTE = 8'hB1,
  parameter int         NUM_COEFS   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  input  logic                  biquad_ready,
  output logic [data_width-1:0] param_in,
  output logic [2:0]            param_target,
  output logic                  write_param,
  output logic                  commit_busy,
  output logic                  frame_done,
  output logic                  frame_error
);

  localparam int              BYTES_PER_COEF = data_width / 8;
  localparam int              POS_W    = (BYTES_PER_COEF > 1) ? $clog2(BYTES_PER_COEF) : 1;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(BYTES_PER_COEF - 1);
  localparam logic [3:0]      LAST_IDX = 4'(NUM_COEFS - 1);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
`ifdef BIQUAD_LOADER_CHECKSUM_EN
    CHECK,
`endif
    COMMIT,
    DONE
  } state_t;

  state_t                state, state_next;
  logic [data_width-1:0] shadow [NUM_COEFS];
  logic [3:0]            coef_idx;
  logic [POS_W-1:0]      byte_pos;
  logic [data_width-1:0] cur_shadow, next_coef, shifted;
  logic                  accept, last_byte;
  logic                  err_pulse;

`ifdef BIQUAD_LOADER_CHECKSUM_EN
  logic [7:0] run_sum, rx_sum;
  logic       sum_ok;
  assign sum_ok    = (run_sum == rx_sum);
  assign last_byte = (coef_idx == 4'(NUM_COEFS));
`else
  assign last_byte = (coef_idx == LAST_IDX) && (byte_pos == LAST_POS);
`endif

  assign byte_ready = !reset && (state == IDLE || state == COLLECT);
  assign accept     = byte_valid && byte_ready;

  // coef_idx doubles as the collect pointer and the commit pointer
  always_comb begin
    cur_shadow = '0;
    next_coef  = '0;
    for (int i = 0; i < NUM_COEFS; i++) begin
      if (coef_idx == 4'(i)) cur_shadow = shadow[i];
      if (coef_idx + 4'd1 == 4'(i)) next_coef = shadow[i];
    end
    shifted = (cur_shadow << 8) | data_width'(byte_in);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    write_param = 1'b0;
    commit_busy = 1'b0;
    frame_done  = 1'b0;
    err_pulse   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && byte_in == HEADER_BYTE) state_next = COLLECT;
      end
      COLLECT: begin
`ifdef BIQUAD_LOADER_CHECKSUM_EN
        if (accept && last_byte) state_next = CHECK;
`else
        if (accept && last_byte) state_next = COMMIT;
`endif
      end
`ifdef BIQUAD_LOADER_CHECKSUM_EN
      CHECK: begin
        err_pulse  = !sum_ok;
        state_next = sum_ok ? COMMIT : IDLE;
      end
`endif
      COMMIT: begin
        commit_busy = 1'b1;
        write_param = biquad_ready;
        if (biquad_ready && coef_idx == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (reset) begin
      write_param = 1'b0;
      commit_busy = 1'b0;
      frame_done  = 1'b0;
      err_pulse   = 1'b0;
    end
  end

`ifdef BIQUAD_LOADER_CHECKSUM_EN
  assign frame_error = err_pulse;
`else
  assign frame_error = 1'b0;
`endif

  // param_in/param_target are preloaded for index 0 and then advance only on each strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      coef_idx     <= '0;
      byte_pos     <= '0;
      param_in     <= '0;
      param_target <= '0;
      for (int i = 0; i < NUM_COEFS; i++) shadow[i] <= '0;
`ifdef BIQUAD_LOADER_CHECKSUM_EN
      run_sum      <= '0;
      rx_sum       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept && byte_in == HEADER_BYTE) begin
            coef_idx <= '0;
            byte_pos <= '0;
`ifdef BIQUAD_LOADER_CHECKSUM_EN
            run_sum  <= '0;
`endif
          end
        end
        COLLECT: begin
          if (accept) begin
            if (coef_idx < 4'(NUM_COEFS)) begin
              for (int i = 0; i < NUM_COEFS; i++)
                if (coef_idx == 4'(i)) shadow[i] <= shifted;
`ifdef BIQUAD_LOADER_CHECKSUM_EN
              run_sum <= run_sum ^ byte_in;
`endif
              if (byte_pos == LAST_POS) begin
                byte_pos <= '0;
                coef_idx <= coef_idx + 4'd1;
              end else begin
                byte_pos <= byte_pos + POS_W'(1);
              end
            end
`ifdef BIQUAD_LOADER_CHECKSUM_EN
            else rx_sum <= byte_in;
`else
            if (last_byte) begin
              coef_idx     <= '0;
              param_target <= 3'd0;
              param_in     <= (NUM_COEFS == 1) ? shifted : shadow[0];
            end
`endif
          end
        end
`ifdef BIQUAD_LOADER_CHECKSUM_EN
        CHECK: begin
          coef_idx     <= '0;
          param_target <= 3'd0;
          param_in     <= shadow[0];
        end
`endif
        COMMIT: begin
          if (biquad_ready && coef_idx != LAST_IDX) begin
            coef_idx     <= coef_idx + 4'd1;
            param_target <= param_target + 3'd1;
            param_in     <= next_coef;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_biquad_coef_loader.sv
// Scoreboard bench for biquad_coef_loader: a frame-level model predicts writes, monitor compares them.
// Follows BIQUAD_LOADER_CHECKSUM_EN to decide whether frames carry a trailing checksum byte.
module tb_biquad_coef_loader;

  localparam int         DW  = 16;
  localparam int         NUM = 5;
  localparam int         BPC = DW / 8;
  localparam logic [7:0] HDR = 8'hB1;
`ifdef BIQUAD_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam int FRAME_LEN = NUM * BPC + (CSUM ? 1 : 0);
  localparam int LATENCY   = CSUM ? 2 : 1;

  logic          clk, reset;
  logic [7:0]    byte_in;
  logic          byte_valid, byte_ready, biquad_ready;
  logic [DW-1:0] param_in;
  logic [2:0]    param_target;
  logic          write_param, commit_busy, frame_done, frame_error;

  biquad_coef_loader #(.data_width(DW), .HEADER_BYTE(HDR), .NUM_COEFS(NUM)) dut (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .biquad_ready(biquad_ready), .param_in(param_in),
    .param_target(param_target), .write_param(write_param), .commit_busy(commit_busy),
    .frame_done(frame_done), .frame_error(frame_error)
  );

  typedef struct {
    int            kind;   // 0 write, 1 done, 2 error
    int            target;
    logic [DW-1:0] value;
  } exp_t;

  exp_t          expQ[$];
  exp_t          monE;
  logic [7:0]    frameBytes[$];
  logic [DW-1:0] coefs[NUM];
  int            checks = 0;
  int            errors = 0;
  bit            readyForce = 1'b1;
  bit            gaps = 1'b0;
  bit            inFrame = 1'b0;
  bit            firstPending = 1'b0;
  bit            frameForced = 1'b0;
  time           frameEndTime, lastWriteTime;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    biquad_ready = readyForce ? 1'b1 : ($urandom_range(0, 99) < 60);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    inFrame = 1'b0;
    frameBytes.delete();
  endtask

  // Frame-level reference: hunt for the header, gather a frame, predict the resulting events
  task automatic modelByte(input logic [7:0] b);
    logic [7:0] x;
    longint     v;
    bit         good;
    if (!inFrame) begin
      if (b == HDR) begin
        inFrame = 1'b1;
        frameBytes.delete();
      end
    end else begin
      frameBytes.push_back(b);
      if (frameBytes.size() == FRAME_LEN) begin
        x = 8'h00;
        for (int k = 0; k < NUM * BPC; k++) x = x ^ frameBytes[k];
        good = 1'b1;
        if (CSUM) good = (x == frameBytes[FRAME_LEN-1]);
        if (good) begin
          for (int c = 0; c < NUM; c++) begin
            v = 0;
            for (int k = 0; k < BPC; k++) v = v * 256 + longint'(frameBytes[c*BPC+k]);
            expQ.push_back('{0, c, DW'(v)});
          end
          expQ.push_back('{1, 0, '0});
        end else begin
          expQ.push_back('{2, 0, '0});
        end
        frameEndTime = $time;
        firstPending = 1'b1;
        frameForced  = readyForce;
        inFrame      = 1'b0;
      end
    end
  endtask

  // Offer one byte (called at a falling edge) until the loader takes it
  task automatic applyStimulus(input logic [7:0] b);
    int waitCnt = 0;
    bit done = 1'b0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!done) begin
      #2;
      if (byte_ready) begin
        @(posedge clk);
        modelByte(b);
        done = 1'b1;
      end else begin
        waitCnt++;
        if (waitCnt > 300) begin
          checkOutput("byte_accept_timeout", 32'd0, 32'd1);
          done = 1'b1;
        end
        @(negedge clk);
      end
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic sendFrame(input bit corrupt);
    logic [7:0] b, x;
    x = 8'h00;
    applyStimulus(HDR);
    for (int c = 0; c < NUM; c++)
      for (int k = 0; k < BPC; k++) begin
        b = 8'(coefs[c] >> (8 * (BPC - 1 - k)));
        x = x ^ b;
        if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
        applyStimulus(b);
      end
    if (CSUM) applyStimulus(corrupt ? (x ^ 8'h01) : x);
  endtask

  task automatic drain();
    int n = 0;
    while ((expQ.size() != 0 || commit_busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_timeout", 32'(n < 400), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_byte_ready"},   32'(byte_ready),   32'd0);
    checkOutput({tag, "_write_param"},  32'(write_param),  32'd0);
    checkOutput({tag, "_param_in"},     32'(param_in),     32'd0);
    checkOutput({tag, "_param_target"}, 32'(param_target), 32'd0);
    checkOutput({tag, "_commit_busy"},  32'(commit_busy),  32'd0);
    checkOutput({tag, "_frame_done"},   32'(frame_done),   32'd0);
    checkOutput({tag, "_frame_error"},  32'(frame_error),  32'd0);
  endtask

  // Monitor: every strobe or pulse must match the head of the expectation queue
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      if (commit_busy) checkOutput("byte_ready_in_commit", 32'(byte_ready), 32'd0);
      if (write_param) begin
        checkOutput("strobe_while_stalled", 32'(biquad_ready), 32'd1);
        checkOutput("busy_during_write", 32'(commit_busy), 32'd1);
        if (expQ.size() == 0) checkOutput("unexpected_write", 32'd1, 32'd0);
        else begin
          monE = expQ.pop_front();
          checkOutput("write_kind", 32'(monE.kind), 32'd0);
          checkOutput("param_target", 32'(param_target), 32'(monE.target));
          checkOutput("param_in", 32'(param_in), 32'(monE.value));
          if (firstPending) begin
            if (frameForced)
              checkOutput("first_write_latency", 32'(($time - frameEndTime - 6) / 10 + 1), 32'(LATENCY));
            firstPending = 1'b0;
          end else if (frameForced) begin
            checkOutput("write_spacing", 32'($time - lastWriteTime), 32'd10);
          end
          lastWriteTime = $time;
        end
      end
      if (frame_done) begin
        if (expQ.size() == 0) checkOutput("unexpected_done", 32'd1, 32'd0);
        else begin
          monE = expQ.pop_front();
          checkOutput("done_kind", 32'(monE.kind), 32'd1);
          if (frameForced) checkOutput("done_after_last_write", 32'($time - lastWriteTime), 32'd10);
        end
      end
      if (frame_error) begin
        if (expQ.size() == 0) checkOutput("unexpected_error", 32'd1, 32'd0);
        else begin
          monE = expQ.pop_front();
          checkOutput("error_kind", 32'(monE.kind), 32'd2);
          firstPending = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] b;
    reset = 1'b1;
    byte_valid = 1'b0;
    byte_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("por");
    reset = 1'b0;
    @(negedge clk);

    // Reference frame, ready held high
    readyForce = 1'b1;
    coefs = '{16'h4000, 16'h0000, 16'hC000, 16'h1000, 16'hF000};
    sendFrame(1'b0);
    drain();

    // Same frame with the biquad stalling randomly
    readyForce = 1'b0;
    sendFrame(1'b0);
    drain();

    // Junk ahead of a frame is dropped
    readyForce = 1'b1;
    foreach (coefs[i]) coefs[i] = DW'(16'h1111 * (i + 1));
    applyStimulus(8'h00); checkOutput("junk_ready_0", 32'(byte_ready), 32'd1);
    applyStimulus(8'hFF); checkOutput("junk_ready_1", 32'(byte_ready), 32'd1);
    applyStimulus(8'h12); checkOutput("junk_ready_2", 32'(byte_ready), 32'd1);
    sendFrame(1'b0);
    drain();

    // A byte held during commit waits, then a frame containing header values as data
    sendFrame(1'b0);
    applyStimulus(8'h55);
    coefs = '{16'hB1B1, 16'h00B1, 16'hB100, 16'h7FFF, 16'h8001};
    sendFrame(1'b0);
    drain();

    // Reset mid-frame, then a clean frame
    applyStimulus(HDR);
    for (int k = 0; k < 5; k++) applyStimulus(8'hA0 + 8'(k));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkResetOutputs("midframe");
    modelReset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    coefs = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
    sendFrame(1'b0);
    drain();

    if (CSUM) begin
      coefs = '{16'h4000, 16'h0000, 16'hC000, 16'h1000, 16'hF000};
      sendFrame(1'b0);
      drain();
      sendFrame(1'b1);
      drain();
    end

    // Randomised frames, junk, gaps and stalls
    for (int f = 0; f < 20; f++) begin
      readyForce = 1'($urandom_range(0, 1));
      gaps       = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) begin
        do b = 8'($urandom_range(0, 255)); while (b == HDR);
        applyStimulus(b);
      end
      foreach (coefs[i]) begin
        coefs[i] = DW'($urandom);
        if ($urandom_range(0, 3) == 0) coefs[i][15:8] = HDR;
      end
      sendFrame(CSUM && ($urandom_range(0, 3) == 0));
      drain();
    end

    checkOutput("leftover_expectations", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
